mnist_img_loader: RTL and testbench
===================================

Name: mnist_img_loader

Overview:
- Front-end producer for the MNIST accelerator.
- Receives one image as a byte stream over a valid/ready interface and assembles it into the 6272-bit img_data bus.
- Pulses the accelerator start and waits for done, then returns the predicted digit as a one-byte response on a second valid/ready interface.
- Replaces fixed BRAM test images, so arbitrary images can be fed from a UART/host bridge.

Parameters:
IMG_SIZE, 784, pixels per frame
PIX_W, 8, bits per pixel (img_data width = IMG_SIZE*PIX_W)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
s_valid  in  1  input byte valid
s_data  in  8  pixel byte
s_last  in  1  marks final byte of frame
s_ready  out  1  loader accepts byte
img_data  out  6272  assembled image to accelerator; pixel i at [i*8 +: 8]
accel_start  out  1  one-cycle start pulse to accelerator
accel_done  in  1  accelerator done (level)
pred_digit  in  4  accelerator result
res_valid  out  1  response byte valid
res_data  out  8  response byte
res_ready  in  1  response consumer ready
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst low, async) values:
  - state=IDLE, pixel counter=0, img_data=0, accel_start=0, res_valid=0, res_data=0, busy=0.
  - s_ready=1 once reset is released.
- Transfer rule: a byte transfers on a rising clk edge with s_valid && s_ready. s_ready=1 in IDLE, RECV and DRAIN, else 0.
- States:
  - IDLE: first accepted byte is written as pixel 0, cnt<=1, go RECV. If that byte also has s_last and IMG_SIZE>1, treat as short frame.
  - RECV: each accepted byte is written to img_data[cnt*8 +: 8], cnt++. Outcomes:
    - s_last on byte cnt==IMG_SIZE-1: go START.
    - s_last on byte cnt<IMG_SIZE-1: short frame, res_data=8'hE1, go RESP.
    - Byte cnt==IMG_SIZE-1 without s_last: overrun, go DRAIN.
  - DRAIN: accept and discard bytes until one with s_last, then res_data=8'hE2, go RESP. img_data is not modified in DRAIN.
  - START: accel_start=1 for exactly one cycle, go WAIT.
  - WAIT: register done_q<=accel_done each cycle; done_q is forced to 1 on entry to WAIT. On accel_done && !done_q (rising edge), capture res_data={4'h0,pred_digit} and go RESP. This edge rule prevents a done level held over from the previous run from completing the frame.
  - RESP: res_valid=1 and res_data held stable. On res_valid && res_ready: res_valid<=0, go IDLE.
- Latency:
  - Last good byte accepted at edge N; accel_start high during cycle N+1.
  - Done rise sampled at edge M; res_valid high from cycle M+1.
- img_data holds the last written pixels between frames. Bytes of a short or overrun frame partially overwrite it; the accelerator is not started for errored frames.
- No timeout in WAIT.
- Reset asserted mid-frame or mid-wait: abort immediately to IDLE with all reset values; no response is emitted.
- Simultaneous res_ready and new s_valid while in RESP: s_ready=0, so no byte is accepted until IDLE (one-cycle bubble).
- Counter is 10 bits; it never wraps, because DRAIN is entered at IMG_SIZE-1.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - Frame is IMG_SIZE+1 bytes. The extra byte (carrying s_last) is the 8-bit mod-256 sum of all pixel bytes.
  - A running sum is accumulated in RECV. s_last is expected on byte index IMG_SIZE, and the overrun check moves to that index.
  - Checksum mismatch: res_data=8'hE3, go RESP, accelerator not started. Match: go START as normal.
- When undefined: frame is IMG_SIZE bytes, and no sum register or E3 code exists.

Test Plan:
1. Reset, then stream 784 bytes with value i[7:0], s_last on byte 783; model returns done after 100 cycles with pred_digit=6 -> img_data[i*8+:8]==i[7:0] for all i, one accel_start pulse, res_data==8'h06, res_valid held until res_ready.
2. Send 500 bytes with s_last on byte 499 -> res_data==8'hE1, accel_start never asserted, back to IDLE after handshake.
3. Send 790 bytes, s_last on byte 789 -> bytes 784..789 discarded, img_data pixels 0..783 match, res_data==8'hE2.
4. Hold accel_done high from a previous run; send a good frame; drop done for 5 cycles, then raise it with pred_digit=3 -> response 8'h03 only after the new rising edge.
5. Deassert rst for 2 cycles at byte 300 of a frame -> all outputs at reset values, no response; the next full frame completes normally.
6. (LOADER_CHECKSUM_EN) Good frame plus correct sum -> normal result; same frame with sum+1 -> res_data==8'hE3, no accel_start.

Source files
------------

// File: rtl/mnist_img_loader_if.sv
// Byte-stream input and one-byte response handshakes between the host bridge and the image loader.
// The master drives the pixel stream and consumes the response. The slave is the loader.
interface mnist_img_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;

  modport master (
    output s_valid, s_data, s_last, res_ready,
    input  s_ready, res_valid, res_data
  );

  modport slave (
    input  s_valid, s_data, s_last, res_ready,
    output s_ready, res_valid, res_data
  );
endinterface

// File: rtl/mnist_img_loader.sv
// Assembles one IMG_SIZE-byte frame into img_data, pulses the accelerator, and returns the digit or an error code (E1 short, E2 overrun).
// With LOADER_CHECKSUM_EN defined, a trailing mod-256 pixel sum byte is expected, and a mismatch answers E3.
module mnist_img_loader #(
  parameter int IMG_SIZE = 784,
  parameter int PIX_W    = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  mnist_img_loader_if.slave         if_bus,
  output logic [IMG_SIZE*PIX_W-1:0] o_img_data,
  output logic                      o_accel_start,
  input  logic                      i_accel_done,
  input  logic [3:0]                i_pred_digit,
  output logic                      o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_DRAIN, S_START, S_WAIT, S_RESP
  } state_t;

  localparam logic [9:0] PIX_LAST = 10'(IMG_SIZE - 1);
`ifdef LOADER_CHECKSUM_EN
  localparam logic [9:0] LAST_IDX = 10'(IMG_SIZE);
`else
  localparam logic [9:0] LAST_IDX = 10'(IMG_SIZE - 1);
`endif

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [9:0]                r_cnt;
  logic [9:0]                w_cnt_nxt;
  logic [9:0]                w_idx;
  logic [IMG_SIZE*PIX_W-1:0] r_img;
  logic [7:0]                r_res_data;
  logic [7:0]                w_res_nxt;
  logic                      r_done_q;
  logic                      w_rdy;
  logic                      w_acc;
  logic                      w_wr_en;
  logic                      w_res_ld;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                r_sum;
  logic [7:0]                w_sum_nxt;
`endif

  assign w_rdy = (r_state == S_IDLE) || (r_state == S_RECV) || (r_state == S_DRAIN);
  assign w_acc = if_bus.s_valid && w_rdy;
  // The first byte of a frame is always pixel 0, whatever the counter holds.
  assign w_idx = (r_state == S_IDLE) ? 10'd0 : r_cnt;

  assign if_bus.s_ready  = w_rdy;
  assign if_bus.res_valid = (r_state == S_RESP);
  assign if_bus.res_data  = r_res_data;
  assign o_img_data       = r_img;
  assign o_accel_start    = (r_state == S_START);
  assign o_busy           = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_res_ld    = 1'b0;
    w_res_nxt   = r_res_data;
    case (r_state)
      S_IDLE, S_RECV: begin
        if (w_acc) begin
          w_wr_en   = (w_idx <= PIX_LAST);
          w_cnt_nxt = w_idx + 10'd1;
          if (if_bus.s_last) begin
            if (w_idx == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
              if (if_bus.s_data == r_sum) begin
                w_state_nxt = S_START;
              end else begin
                w_res_ld    = 1'b1;
                w_res_nxt   = 8'hE3;
                w_state_nxt = S_RESP;
              end
`else
              w_state_nxt = S_START;
`endif
            end else begin
              w_res_ld    = 1'b1;
              w_res_nxt   = 8'hE1;
              w_state_nxt = S_RESP;
            end
          end else if (w_idx == LAST_IDX) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_RECV;
          end
        end
      end
      S_DRAIN: begin
        if (w_acc && if_bus.s_last) begin
          w_res_ld    = 1'b1;
          w_res_nxt   = 8'hE2;
          w_state_nxt = S_RESP;
        end
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // Only a fresh rising edge of done counts, so a level left over from the last run is ignored.
        if (i_accel_done && !r_done_q) begin
          w_res_ld    = 1'b1;
          w_res_nxt   = {4'h0, i_pred_digit};
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (if_bus.res_ready) begin
          w_cnt_nxt   = 10'd0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef LOADER_CHECKSUM_EN
    w_sum_nxt = r_sum;
    if (w_wr_en) begin
      w_sum_nxt = (w_idx == 10'd0) ? if_bus.s_data : r_sum + if_bus.s_data;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 10'd0;
      r_img      <= '0;
      r_res_data <= 8'h00;
      r_done_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum      <= 8'h00;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_wr_en) begin
        r_img[w_idx*PIX_W +: PIX_W] <= if_bus.s_data[PIX_W-1:0];
      end
      if (w_res_ld) begin
        r_res_data <= w_res_nxt;
      end
      if (r_state == S_START) begin
        r_done_q <= 1'b1;
      end else if (r_state == S_WAIT) begin
        r_done_q <= i_accel_done;
      end
`ifdef LOADER_CHECKSUM_EN
      r_sum <= w_sum_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mnist_img_loader.sv
// Directed-plus-random bench for mnist_img_loader: frames are scored against a byte-array image model and a length/checksum rule.
module tb_mnist_img_loader;
  localparam int IMG_SIZE = 784;
  localparam int PIX_W    = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam int GOOD_LEN = IMG_SIZE + 1;
`else
  localparam int GOOD_LEN = IMG_SIZE;
`endif
  localparam int RUN_ACCEL = 256;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [IMG_SIZE*PIX_W-1:0] img_data;
  logic                      accel_start;
  logic                      accel_done = 1'b0;
  logic [3:0]                pred_digit = 4'h0;
  logic                      busy;

  mnist_img_loader_if bus_if ();

  mnist_img_loader #(.IMG_SIZE(IMG_SIZE), .PIX_W(PIX_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .if_bus       (bus_if.slave),
    .o_img_data   (img_data),
    .o_accel_start(accel_start),
    .i_accel_done (accel_done),
    .i_pred_digit (pred_digit),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  logic [7:0] ref_img [IMG_SIZE];
  logic [7:0] frm [$];

  always @(posedge clk) if (accel_start === 1'b1) start_cnt <= start_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag);
    logic [IMG_SIZE*PIX_W-1:0] e;
    for (int i = 0; i < IMG_SIZE; i++) e[i*PIX_W +: PIX_W] = ref_img[i];
    checks++;
    assert (img_data === e) else begin
      int bad;
      bad = 0;
      for (int i = IMG_SIZE - 1; i >= 0; i--) if (img_data[i*PIX_W +: PIX_W] !== e[i*PIX_W +: PIX_W]) bad = i;
      errors++;
      $error("FAIL %s: pixel %0d observed=%0h expected=%0h", tag, bad, img_data[bad*PIX_W +: PIX_W], e[bad*PIX_W +: PIX_W]);
    end
  endtask

  // len bytes; ramp gives pixel i = i[7:0]; in checksum builds byte IMG_SIZE carries sum+sum_adj.
  task automatic make_frame(input int len, input bit ramp, input int sum_adj);
    int sum;
    sum = 0;
    frm.delete();
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = ramp ? 8'(i) : 8'($urandom_range(0, 255));
`ifdef LOADER_CHECKSUM_EN
      if (i == IMG_SIZE) b = 8'(sum + sum_adj);
`endif
      if (i < IMG_SIZE) sum += int'(b);
      frm.push_back(b);
    end
  endtask

  // Reference: pixels land in order, frame length decides the outcome, optional trailing sum is verified.
  function automatic int model_frame();
    int n;
    int sum;
    n = frm.size();
    sum = 0;
    for (int i = 0; i < n && i < IMG_SIZE; i++) begin
      ref_img[i] = frm[i];
      sum += int'(frm[i]);
    end
    if (n < GOOD_LEN) return 8'hE1;
    if (n > GOOD_LEN) return 8'hE2;
`ifdef LOADER_CHECKSUM_EN
    if (frm[IMG_SIZE] != 8'(sum)) return 8'hE3;
`endif
    return RUN_ACCEL;
  endfunction

  // Called at a negedge; returns at the negedge after the last accepted byte.
  task automatic send_frame(input int stop_at);
    int i;
    int guard;
    logic xfer;
    i = 0;
    guard = 0;
    while (i < frm.size() && i != stop_at && guard < 20000) begin
      bus_if.s_valid = ($urandom_range(0, 3) != 0);
      bus_if.s_data  = frm[i];
      bus_if.s_last  = (i == frm.size() - 1);
      xfer = bus_if.s_valid && (bus_if.s_ready === 1'b1);
      @(negedge clk);
      if (xfer) i++;
      guard++;
    end
    bus_if.s_valid = 1'b0;
    bus_if.s_last  = 1'b0;
    if (guard >= 20000) chk("send_timeout", 32'(i), 32'(frm.size()));
  endtask

  task automatic expect_resp(input string tag, input logic [7:0] code);
    int t;
    t = 0;
    while (bus_if.res_valid !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " res_valid"}, 32'(bus_if.res_valid), 32'd1);
    chk({tag, " res_data"}, 32'(bus_if.res_data), 32'(code));
    chk({tag, " s_ready_in_resp"}, 32'(bus_if.s_ready), 32'd0);
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      chk({tag, " res_hold"}, {23'd0, bus_if.res_valid, bus_if.res_data}, {23'd0, 1'b1, code});
    end
    bus_if.res_ready = 1'b1;
    @(negedge clk);
    bus_if.res_ready = 1'b0;
    chk({tag, " after_hs"}, {30'd0, bus_if.res_valid, busy}, 32'd0);
    chk({tag, " s_ready_idle"}, 32'(bus_if.s_ready), 32'd1);
  endtask

  task automatic do_frame(input string tag, input logic [3:0] pred, input int delay, input bit hold_done);
    int exp;
    int s0;
    exp = model_frame();
    s0 = start_cnt;
    send_frame(-1);
    if (exp == RUN_ACCEL) begin
      chk({tag, " start_pulse"}, 32'(accel_start), 32'd1);
      @(negedge clk);
      chk({tag, " start_once"}, {30'd0, accel_start, busy}, 32'd1);
      chk({tag, " start_cnt"}, 32'(start_cnt), 32'(s0 + 1));
      if (hold_done) begin
        repeat (10) @(negedge clk);
        chk({tag, " stale_done_ignored"}, 32'(bus_if.res_valid), 32'd0);
        accel_done = 1'b0;
        repeat (5) @(negedge clk);
      end else begin
        accel_done = 1'b0;
        repeat (delay) @(negedge clk);
        chk({tag, " no_early_res"}, 32'(bus_if.res_valid), 32'd0);
      end
      accel_done = 1'b1;
      pred_digit = pred;
      @(negedge clk);
      chk({tag, " res_latency"}, 32'(bus_if.res_valid), 32'd1);
      expect_resp(tag, {4'h0, pred});
    end else begin
      chk({tag, " err_latency"}, 32'(bus_if.res_valid), 32'd1);
      expect_resp(tag, 8'(exp));
      chk({tag, " no_start"}, 32'(start_cnt), 32'(s0));
    end
    chk_img({tag, " img"});
  endtask

  initial begin
    bus_if.s_valid   = 1'b0;
    bus_if.s_data    = 8'h00;
    bus_if.s_last    = 1'b0;
    bus_if.res_ready = 1'b0;
    for (int i = 0; i < IMG_SIZE; i++) ref_img[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_outputs", {28'd0, busy, accel_start, bus_if.res_valid, 1'b0}, 32'd0);
    chk("rst_res_data", 32'(bus_if.res_data), 32'd0);
    chk_img("rst_img");
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {30'd0, bus_if.s_ready, busy}, 32'd2);

    make_frame(GOOD_LEN, 1'b1, 0);
    do_frame("ramp", 4'd6, 100, 1'b0);

    make_frame(GOOD_LEN, 1'b0, 0);
    do_frame("held_done", 4'd3, 0, 1'b1);

    make_frame(500, 1'b0, 0);
    do_frame("short", 4'd0, 0, 1'b0);

    make_frame(790, 1'b0, 0);
    do_frame("overrun", 4'd0, 0, 1'b0);

    make_frame(GOOD_LEN, 1'b0, 0);
    send_frame(300);
    rst = 1'b0;
    #1;
    for (int i = 0; i < IMG_SIZE; i++) ref_img[i] = 8'h00;
    chk("midrst_outputs", {29'd0, busy, accel_start, bus_if.res_valid}, 32'd0);
    chk("midrst_res_data", 32'(bus_if.res_data), 32'd0);
    chk_img("midrst_img");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_resp", {30'd0, bus_if.res_valid, busy}, 32'd0);
    make_frame(GOOD_LEN, 1'b0, 0);
    do_frame("after_rst", 4'($urandom_range(0, 9)), 20, 1'b0);

    for (int k = 0; k < 2; k++) begin
      make_frame(GOOD_LEN, 1'b0, 0);
      do_frame("rand", 4'($urandom_range(0, 9)), int'($urandom_range(1, 30)), 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    make_frame(GOOD_LEN, 1'b0, 0);
    do_frame("sum_ok", 4'($urandom_range(0, 9)), 10, 1'b0);
    make_frame(GOOD_LEN, 1'b0, 1);
    do_frame("sum_bad", 4'd0, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
